// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR result BCD converter.
// Holds the FSM state encoding and the datapath geometry.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int              DATA_W    = 12;
    localparam int              DIGITS    = 4;
    localparam int              BCD_W     = 4 * DIGITS;
    localparam int              CNT_W     = 4;
    localparam logic [CNT_W-1:0] ITER_LAST = 4'd11;
    localparam logic [DIGITS-1:0] DP_MASK = 4'b0100;

endpackage : fir_pkg

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for a single BCD nibble: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_nibble = (i_nibble >= 4'd5) ? (i_nibble + 4'd3) : i_nibble;
    end

endmodule : bcd_digit_adj

// File: rtl/fir_result_bcd.sv
// Serial double-dabble converter turning the 12-bit FIR result (100*y[n]) into four BCD
// digits for display, with a valid/ready handshake on both sides.
module fir_result_bcd
    import fir_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [BCD_W-1:0]  o_bcd,
    output logic [DIGITS-1:0] o_dp,
    output logic              o_busy
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  bin_q,   bin_d;
    logic [BCD_W-1:0]   acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               busy_q,  busy_d;

    logic [BCD_W-1:0]   acc_adj;
    logic [BCD_W-1:0]   acc_shift;
    logic [DATA_W-1:0]  bin_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .i_nibble (acc_q[4*g +: 4]),
            .o_nibble (acc_adj[4*g +: 4])
        );
    end

    // One double-dabble iteration: the binary MSB moves into the adjusted BCD accumulator.
    always_comb begin
        acc_shift = (acc_adj << 1) | {{(BCD_W-1){1'b0}}, bin_q[DATA_W-1]};
        bin_shift = bin_q << 1;
    end

    always_comb begin
        // NOTE: every variable gets a default before the case, otherwise paths that do
        // not assign it would infer a latch.
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;

        case (state_q)
            IDLE: begin
                if (i_valid && ready_q) begin
                    bin_d   = i_data;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_shift;
                bin_d = bin_shift;
                if (cnt_q == ITER_LAST) begin
                    bcd_d   = acc_shift;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Input side stays closed here, so a word offered alongside i_ready waits for IDLE.
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
        busy_d  = (state_d == SHIFT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_bcd   = bcd_q;
    assign o_dp    = DP_MASK;

endmodule : fir_result_bcd
